// File: rtl/alu_pkg.sv
// Shared opcode/state types and helpers for the execute-stage sequencer.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_ADC  = 4'h2,
    OP_SBC  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_NOT  = 4'h6,
    OP_XNOR = 4'h7,
    OP_ASR  = 4'h8,
    OP_LSL  = 4'h9,
    OP_LSR  = 4'hA,
    OP_ROL  = 4'hB,
    OP_ROR  = 4'hC,
    OP_RRC  = 4'hD
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS1 = 2'd1,
    S_PASS2 = 2'd2,
    S_DONE  = 2'd3
  } exec_state_e;

  // Ops that can be split across two byte passes; the rest run once on the low byte.
  function automatic logic is_chainable(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC,
      OP_AND, OP_OR, OP_NOT, OP_XNOR,
      OP_ASR, OP_LSR, OP_RRC:          is_chainable = 1'b1;
      default:                         is_chainable = 1'b0;
    endcase
  endfunction

  function automatic logic is_arith(input logic [3:0] op);
    is_arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/ALU_8_BIT.sv
// Purely combinational 8-bit ALU; carry out of subtracts is a borrow.
module ALU_8_BIT
  import alu_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [ALU_W-1:0] i_a,
  input  logic [ALU_W-1:0] i_b,
  input  logic [OP_W-1:0]  i_op,
  input  logic             i_c_in,
  output logic [ALU_W-1:0] o_res,
  output logic             o_c_out
);

  logic [ALU_W:0] w_wide;

  always_comb begin
    w_wide  = '0;
    o_res   = '0;
    o_c_out = 1'b0;
    case (i_op)
      OP_ADD:  w_wide = {1'b0, i_a} + {1'b0, i_b};
      OP_SUB:  w_wide = {1'b0, i_a} - {1'b0, i_b};
      OP_ADC:  w_wide = {1'b0, i_a} + {1'b0, i_b} + {{ALU_W{1'b0}}, i_c_in};
      OP_SBC:  w_wide = {1'b0, i_a} - {1'b0, i_b} - {{ALU_W{1'b0}}, i_c_in};
      OP_AND:  w_wide = {1'b0, i_a & i_b};
      OP_OR:   w_wide = {1'b0, i_a | i_b};
      OP_NOT:  w_wide = {1'b0, ~i_a};
      OP_XNOR: w_wide = {1'b0, ~(i_a ^ i_b)};
      OP_ASR:  w_wide = {i_a[0], i_a[7], i_a[7:1]};
      OP_LSL:  w_wide = {i_a[7], i_a[6:0], 1'b0};
      OP_LSR:  w_wide = {i_a[0], 1'b0, i_a[7:1]};
      OP_ROL:  w_wide = {i_a[7], i_a[6:0], i_a[7]};
      OP_ROR:  w_wide = {i_a[0], i_a[0], i_a[7:1]};
      OP_RRC:  w_wide = {i_a[0], i_c_in, i_a[7:1]};
      default: w_wide = '0;
    endcase
    o_res   = w_wide[ALU_W-1:0];
    o_c_out = w_wide[ALU_W];
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage sequencer: one or two byte passes through ALU_8_BIT, owns the C/Z/N flags.
module alu_exec
  import alu_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic            wide,
  input  logic [15:0]     a,
  input  logic [15:0]     b,
  input  logic            c_set,
  input  logic            c_clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     result,
  output logic            flag_c,
  output logic            flag_z,
  output logic            flag_n
);

  exec_state_e      r_state, w_state_nxt;
  logic [OP_W-1:0]  r_op;
  logic             r_wide;
  logic [15:0]      r_a, r_b;
  logic [15:0]      r_result;
  logic             r_flag_c, r_flag_z, r_flag_n;
  logic             r_c_p1;

  logic [ALU_W-1:0] w_alu_a, w_alu_b, w_alu_res;
  logic [OP_W-1:0]  w_alu_op;
  logic             w_alu_cin, w_alu_cout;
  logic             w_chain, w_last;
  logic [15:0]      w_res_full;
  logic             w_c_nxt;

  assign w_chain   = r_wide && is_chainable(r_op);
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign flag_c    = r_flag_c;
  assign flag_z    = r_flag_z;
  assign flag_n    = r_flag_n;

  // Per-pass operand, opcode and carry-in steering onto the shared ALU
  always_comb begin
    w_alu_a   = r_a[7:0];
    w_alu_b   = r_b[7:0];
    w_alu_op  = r_op;
    w_alu_cin = 1'b0;
    if (r_state == S_PASS2) begin
      w_alu_a = r_a[15:8];
      w_alu_b = r_b[15:8];
    end
    case (r_op)
      OP_ADD, OP_SUB: begin
        if (r_state == S_PASS2) begin
          w_alu_op  = (r_op == OP_ADD) ? OP_ADC : OP_SBC;
          w_alu_cin = r_c_p1;
        end
      end
      OP_ADC, OP_SBC: w_alu_cin = (r_state == S_PASS2) ? r_c_p1 : r_flag_c;
      OP_ASR, OP_LSR, OP_RRC: begin
        if (w_chain && r_state == S_PASS1) begin
          w_alu_op  = OP_RRC;
          w_alu_cin = r_a[8];
        end else if (w_chain && r_state == S_PASS2 && r_op == OP_RRC) begin
          w_alu_cin = r_flag_c;
        end
      end
      default: ;
    endcase
  end

  ALU_8_BIT #(.OP_W(OP_W)) u_alu (
    .i_a     (w_alu_a),
    .i_b     (w_alu_b),
    .i_op    (w_alu_op),
    .i_c_in  (w_alu_cin),
    .o_res   (w_alu_res),
    .o_c_out (w_alu_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_PASS1;
      S_PASS1: w_state_nxt = w_chain ? S_PASS2 : S_DONE;
      S_PASS2: w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Full result and carry as they will stand on the edge entering DONE
  always_comb begin
    w_res_full = (r_state == S_PASS1) ? {8'h00, w_alu_res} : {w_alu_res, r_result[7:0]};
    w_last     = (r_state == S_PASS2) || (r_state == S_PASS1 && !w_chain);
    w_c_nxt    = r_flag_c;
    if (is_arith(r_op))
      w_c_nxt = w_alu_cout;
    else if (r_op == OP_RRC)
      w_c_nxt = (r_state == S_PASS1) ? w_alu_cout : r_c_p1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_c_p1   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (c_clr)      r_flag_c <= 1'b0;
          else if (c_set) r_flag_c <= 1'b1;
        end
        S_PASS1: begin
          r_result <= w_res_full;
          r_c_p1   <= w_alu_cout;
        end
        S_PASS2: r_result <= w_res_full;
        default: ;
      endcase
      if (w_last) begin
        r_flag_c <= w_c_nxt;
        r_flag_z <= w_chain ? (w_res_full == 16'h0000) : (w_res_full[7:0] == 8'h00);
        r_flag_n <= w_chain ? w_res_full[15] : w_res_full[7];
      end
    end
  end

  // Operand capture on accept; data path needs no reset
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && in_valid) begin
      r_op   <= op;
      r_wide <= wide;
      r_a    <= a;
      r_b    <= b;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed, table-driven bench for alu_exec with hand sequences for flag pulses, backpressure and reset.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic        wide;
  logic [15:0] a, b;
  logic        c_set, c_clr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        flag_c, flag_z, flag_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_exec #(.OP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .wide      (wide),
    .a         (a),
    .b         (b),
    .c_set     (c_set),
    .c_clr     (c_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_n    (flag_n)
  );

  typedef struct {
    logic [3:0]  op;
    logic        wide;
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        n;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is 1 time unit after a rising edge with the block idle.
  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    bit got;
    chk($sformatf("v%0d in_ready", idx), {31'b0, in_ready}, 32'd1);
    op = v.op; wide = v.wide; a = v.a; b = v.b; in_valid = 1'b1;
    lat = 0; got = 0;
    while (!got && lat < 10) begin
      tick();
      in_valid = 1'b0;
      lat++;
      if (out_valid === 1'b1) got = 1;
    end
    if (!got) begin
      chk($sformatf("v%0d out_valid timeout", idx), 32'd0, 32'd1);
    end else begin
      chk($sformatf("v%0d latency", idx), lat, v.lat);
      chk($sformatf("v%0d result", idx), {16'b0, result}, {16'b0, v.res});
      chk($sformatf("v%0d flag_c", idx), {31'b0, flag_c}, {31'b0, v.c});
      chk($sformatf("v%0d flag_z", idx), {31'b0, flag_z}, {31'b0, v.z});
      chk($sformatf("v%0d flag_n", idx), {31'b0, flag_n}, {31'b0, v.n});
    end
    tick();
  endtask

  task automatic pulse_c(input logic s, input logic c);
    c_set = s; c_clr = c;
    tick();
    c_set = 1'b0; c_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit got;
    int vcount;

    //            op    wide  a         b         lat res       c     z     n
    vecs[0]  = '{4'h0, 1'b0, 16'h000A, 16'h0005, 2, 16'h000F, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'h0, 1'b1, 16'h00FF, 16'h0001, 3, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'h1, 1'b1, 16'h0000, 16'h0001, 3, 16'hFFFF, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{4'h2, 1'b0, 16'h00FF, 16'h0001, 2, 16'h0001, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4'h4, 1'b0, 16'h000A, 16'h0005, 2, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{4'hD, 1'b1, 16'h0001, 16'h0000, 3, 16'h8000, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{4'h9, 1'b1, 16'h0080, 16'h0000, 2, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{4'h3, 1'b1, 16'h1234, 16'h0034, 3, 16'h11FF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'h2, 1'b1, 16'h8000, 16'h8000, 3, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{4'h7, 1'b1, 16'hF0F0, 16'hFF00, 3, 16'hF00F, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{4'h6, 1'b0, 16'h1255, 16'h0000, 2, 16'h00AA, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{4'h8, 1'b1, 16'h8003, 16'h0000, 3, 16'hC001, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{4'hA, 1'b0, 16'h0081, 16'h0000, 2, 16'h0040, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{4'hE, 1'b0, 16'h1234, 16'h5678, 2, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{4'hC, 1'b0, 16'h0001, 16'h0000, 2, 16'h0080, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{4'h1, 1'b0, 16'h0005, 16'h0005, 2, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{4'hB, 1'b1, 16'h0180, 16'h0000, 2, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{4'h5, 1'b1, 16'h1200, 16'h0034, 3, 16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{4'hA, 1'b1, 16'h0101, 16'h0000, 3, 16'h0080, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; op = '0; wide = 1'b0; a = '0; b = '0;
    c_set = 1'b0; c_clr = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    chk("reset in_ready",  {31'b0, in_ready},  32'd1);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset result",    {16'b0, result},    32'd0);
    chk("reset flags",     {29'b0, flag_c, flag_z, flag_n}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) run_vec(i, vecs[i]);

    // C is 1 here; simultaneous set and clear must clear, then a lone set sets.
    pulse_c(1'b1, 1'b1);
    chk("c_clr wins", {31'b0, flag_c}, 32'd0);
    pulse_c(1'b1, 1'b0);
    chk("c_set", {31'b0, flag_c}, 32'd1);

    for (int i = 3; i < 19; i++) run_vec(i, vecs[i]);

    // Backpressure: wide SUB 0x0000-0x0001 held in DONE.
    out_ready = 1'b0;
    op = 4'h1; wide = 1'b1; a = 16'h0000; b = 16'h0001; in_valid = 1'b1;
    lat = 0; got = 0;
    while (!got && lat < 10) begin
      tick();
      in_valid = 1'b0;
      lat++;
      if (out_valid === 1'b1) got = 1;
    end
    chk("bp reached done", {31'b0, got}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d out_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp%0d in_ready", k),  {31'b0, in_ready},  32'd0);
      chk($sformatf("bp%0d result", k),    {16'b0, result},    32'h0000FFFF);
      chk($sformatf("bp%0d flags", k),     {29'b0, flag_c, flag_z, flag_n}, 32'b101);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp release in_ready", {31'b0, in_ready}, 32'd1);

    // Reset while the next wide op is in PASS2.
    op = 4'h0; wide = 1'b1; a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst seq pass1 in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("rst seq pass2 out_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b1;
    tick();
    chk("rst mid in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst mid out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst mid result",    {16'b0, result},    32'd0);
    chk("rst mid flags",     {29'b0, flag_c, flag_z, flag_n}, 32'd0);
    rst = 1'b0;
    vcount = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (out_valid === 1'b1) vcount++;
    end
    chk("no out_valid after rst", vcount, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage sequencer that wraps the 8-bit ALU and is the stage directly downstream of decode. It accepts an operation and 8- or 16-bit operands over a valid/ready handshake. It runs one or two ALU passes, chaining carry between bytes, and holds the result plus C/Z/N flags until writeback takes them. It owns the architectural flag register.

## Interface
- `OP_W`, default 4: ALU opcode width; must match the ALU.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: an operation is offered.
- `in_ready` out 1: the block can accept; high only in IDLE.
- `op` in 4: ALU opcode.
  - 0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 AND, 5 OR, 6 NOT, 7 XNOR.
  - 8 ASR, 9 LSL, A LSR, B ROL, C ROR, D RRC.
  - E and F are undefined.
- `wide` in 1: 1 selects a 16-bit operation, 0 an 8-bit one.
- `a` in 16: operand A; in 8-bit mode only `a[7:0]` is used.
- `b` in 16: operand B; ignored by NOT and all shift/rotate ops.
- `c_set` in 1: set C; honoured only in IDLE.
- `c_clr` in 1: clear C; honoured only in IDLE; wins over `c_set`.
- `out_valid` out 1: result and flags are valid.
- `out_ready` in 1: writeback accepts the result.
- `result` out 16: in 8-bit mode `[15:8]` is 0.
- `flag_c`, `flag_z`, `flag_n` out 1 each: architectural flags.

## Operation
- States: IDLE, PASS1, PASS2, DONE.
- IDLE to PASS1 on `in_valid && in_ready`. At that edge `op`, `wide`, `a` and `b` are latched.
- PASS1: the ALU runs on the low bytes and the low result byte is registered.
  - Goes to PASS2 if the op is wide and chainable, otherwise to DONE.
- PASS2: the ALU runs on the high bytes and the high result byte is registered. Goes to DONE.
- DONE: `out_valid` is 1. Goes to IDLE on `out_ready`.
- ALU `c_in` per pass:
  - PASS1 for ADD/SUB: 0.
  - PASS1 for ADC/SBC: the current `flag_c`.
  - PASS2 for ADD/ADC: ALU op ADC, `c_in` = PASS1 `c_out`.
  - PASS2 for SUB/SBC: ALU op SBC, `c_in` = PASS1 `c_out` (borrow convention).
  - All other ops: 0 unless listed under wide shifts.
- Wide logic ops (AND, OR, NOT, XNOR): the same op on both bytes, with no chaining.
- Wide LSR, ASR and RRC:
  - PASS1 issues RRC on `a[7:0]` with `c_in = a[8]`.
  - PASS2 issues the original op on `a[15:8]`; for RRC, `c_in = flag_c`.
- Wide LSL, ROL and ROR are not chainable and execute as 8-bit operations: one pass, `result[15:8]` = 0.
- Ops E and F: `result` = 0, C unchanged, Z and N computed from the 0 result.
- Flag update happens on the edge entering DONE:
  - C: updated only for ADD, SUB, ADC, SBC and RRC.
    - For arithmetic ops it takes the last pass's `c_out`.
    - For 8-bit RRC it takes the PASS1 `c_out`. For wide RRC it takes `a[0]`, which is the PASS1 `c_out`.
    - All other ops leave C unchanged.
  - Z: `result` over the operation width equals 0.
  - N: bit 7 of `result`, or bit 15 if the op is wide and chainable.
- `c_set`/`c_clr` are applied in IDLE, including the accepting cycle. The accepted op therefore sees the new C in PASS1.

## Timing
- Reset values:
  - state IDLE, so `in_ready` = 1.
  - `out_valid` = 0, `result` = 0, all flags = 0.
- Latency from the accept edge to the first `out_valid` cycle: 2 clocks for a single pass, 3 clocks for two passes.
- Throughput:
  - A new op can be accepted only after `out_valid && out_ready`; the earliest acceptance is the cycle after that.
  - There is no overlap between operations.
- Backpressure: in DONE, `result` and the flags are held stable indefinitely.
- `in_ready` is combinational from state and does not depend on `in_valid`.
- Reset mid-operation, in any state: the operation is abandoned and no `out_valid` pulse is produced. All outputs return to their reset values on the next edge.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` enum for the 14 opcodes.
  - `exec_state_e` enum.
  - Constant `ALU_W = 8`.
  - Helper function `is_chainable(op)`.
- The one sub-module is `ALU_8_BIT`, instantiated once.
  - The block multiplexes byte operands, `alu_op` and `c_in` onto it per pass.
  - The ALU stays purely combinational; all registers live in `alu_exec`.

## Test plan
- 8-bit ADD, `a`=0x000A, `b`=0x0005:
  - `out_valid` 2 cycles after accept.
  - `result`=0x000F, C=0, Z=0, N=0.
- Wide ADD, `a`=0x00FF, `b`=0x0001:
  - `out_valid` 3 cycles after accept.
  - `result`=0x0100, C=0, Z=0, N=0.
- Wide SUB, `a`=0x0000, `b`=0x0001: `result`=0xFFFF, C=1, N=1, Z=0.
- `c_set` pulse in IDLE, then 8-bit ADC, `a`=0xFF, `b`=0x01: `result`=0x0001, C=1.
  - Then 8-bit AND, 0x0A & 0x05: `result`=0, Z=1, C stays 1.
- Wide RRC with C=1, `a`=0x0001: `result`=0x8000, C=1, N=1.
  - Then wide LSL, `a`=0x0080: `result`=0x0000, since LSL executes 8-bit.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE.
  - `result` and flags stay stable and `in_ready`=0 throughout.
  - Then assert `rst` during PASS2 of the next wide op: no `out_valid`, and all outputs read 0 the cycle after the reset edge.
